adder_operand_sequencer: RTL and testbench
==========================================

Name: adder_operand_sequencer

Overview:
- Upstream stage of the 32-bit signed Adder; drives its in_0/in_1 operand inputs.
- Operands come from the PS over AXI-GPIO channel 1. A data word plus a control nibble loads each operand.
- A built-in sweep mode steps both operands each tick until in_0 reaches a limit, for bring-up on Ultra96V2.
- Status is returned on GPIO channel 2. A one-cycle update pulse lets downstream logic capture adder_out.

Parameters:
STEP_0, 1, signed increment added to in_0 per sweep tick
STEP_1, 2, signed increment added to in_1 per sweep tick
SWEEP_LIMIT, 10, signed; sweep steps only while in_0 < SWEEP_LIMIT
SWEEP_DIV, 1, sys_clk cycles per sweep tick (>=1)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
gpio_data  in  32  operand value from GPIO ch1
gpio_ctrl  in  4  [0] LOAD, [1] SEL (0=in_0, 1=in_1, level), [2] SWEEP, [3] CLEAR
in_0  out  32  signed operand A to Adder (registered)
in_1  out  32  signed operand B to Adder (registered)
operands_valid  out  1  both operands loaded (state READY/SWEEP/DONE)
operand_update  out  1  one-cycle pulse on the cycle in_0/in_1 take a new value
gpio_status  out  32  status to GPIO ch2

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - in_0=0, in_1=0, operands_valid=0, operand_update=0, gpio_status=0, state=IDLE, overflow=0, step_count=0, div counter=0.
  - ctrl_prev <= gpio_ctrl, so a bit held high through reset release does not register as an edge.
  - Reset mid-sweep aborts immediately.
- Command decode:
  - A command fires when gpio_ctrl bit=1 and ctrl_prev bit=0, with ctrl_prev updated every cycle. SEL is a level, sampled with LOAD.
  - Priority in the same cycle: CLEAR > LOAD > SWEEP.
- Latency: the register update occurs on the edge that samples the rising bit; outputs show the new value after that edge, with no combinational path from input to output.
- States (gpio_status[2:0]): IDLE=0, PARTIAL=1, READY=2, SWEEP=3, DONE=4.
- IDLE/PARTIAL:
  - LOAD writes gpio_data to the selected operand and sets loaded_0 or loaded_1.
  - When both are set, go to READY; otherwise go to PARTIAL.
  - SWEEP is ignored.
- READY: LOAD rewrites the selected operand and stays in READY. SWEEP goes to SWEEP, clears step_count and the divider.
- SWEEP:
  - The divider counts 0..SWEEP_DIV-1; a tick occurs when it equals SWEEP_DIV-1. The first tick is SWEEP_DIV cycles after entry.
  - On a tick where in_0 < SWEEP_LIMIT (signed): in_0 += STEP_0 and in_1 += STEP_1, modulo 2^32 (two's-complement wrap, no saturation), and step_count += 1.
  - On a tick where in_0 >= SWEEP_LIMIT: go to DONE with operands unchanged.
  - LOAD aborts the sweep: the operand is written and the state goes to READY.
  - A SWEEP command while already in SWEEP is ignored.
- DONE: operands hold. SWEEP re-enters SWEEP from the current values; if in_0 is still >= the limit, the next tick returns to DONE with no change. LOAD goes to READY.
- CLEAR (any state): same effect as reset, except ctrl_prev keeps normal edge tracking.
- Overflow:
  - Sticky flag, set when a sweep add signs-overflows: operands of the same sign give a result of the other sign, on either operand.
  - Cleared only by reset or CLEAR.
- operand_update: 1 for exactly one cycle after any LOAD write or sweep increment, even if the value is unchanged. It is 0 on CLEAR/reset.
- gpio_status: [2:0] state, [3] overflow, [4] loaded_0, [5] loaded_1, [7:6]=0, [15:8] step_count (saturates at 255), [31:16]=0. Registered.

Test Plan:
- Load/valid: reset, then LOAD SEL=0 with data=-10 → in_0=-10, state=PARTIAL, valid=0. Then LOAD SEL=1 with data=-10 → in_1=-10, state=READY, valid=1, one operand_update pulse per load.
- Default sweep: from (-10,-10), pulse SWEEP → 20 ticks, final in_0=10, in_1=30, status[15:8]=20, DONE on the 21st tick, overflow=0.
- Divider: SWEEP_DIV=4, operands (8,0), SWEEP → steps at cycles 4 and 8 after entry to (9,2) then (10,4), DONE at cycle 12.
- Overflow wrap: in_0=-100, in_1=0x7FFFFFFF, one tick → in_1=0x80000001, status[3]=1. The flag persists after a new LOAD and clears on CLEAR.
- Priority/abort: mid-sweep, assert LOAD and CLEAR in the same cycle → all zero, IDLE. Separately, LOAD alone mid-sweep → READY with the new operand and no further steps.
- Reset edge: hold gpio_ctrl[0]=1 through sys_rst release → no load fires. Drop and raise it → exactly one load occurs.

Source files
------------

// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer
//   Drives the in_0/in_1 operands of the 32-bit signed Adder. Operands are
//   loaded from the PS over AXI-GPIO channel 1 (data word plus control nibble).
//   A built-in sweep mode steps both operands every SWEEP_DIV cycles while
//   in_0 < SWEEP_LIMIT, for board bring-up. Status goes back on GPIO ch2.
//
// Ports
//   sys_clk         system clock, rising edge
//   sys_rst         synchronous active-high reset
//   gpio_data       operand value (GPIO ch1)
//   gpio_ctrl       [0] LOAD, [1] SEL (0=in_0, 1=in_1), [2] SWEEP, [3] CLEAR
//   in_0, in_1      registered signed operands to the Adder
//   operands_valid  both operands loaded (READY/SWEEP/DONE)
//   operand_update  one-cycle pulse after any operand write or sweep step
//   gpio_status     [2:0] state, [3] overflow, [4] loaded_0, [5] loaded_1,
//                   [15:8] saturating step count, rest zero
module adder_operand_sequencer #(
  parameter int signed   STEP_0      = 1,
  parameter int signed   STEP_1      = 2,
  parameter int signed   SWEEP_LIMIT = 10,
  parameter int unsigned SWEEP_DIV   = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic        [31:0] gpio_data,
  input  logic        [3:0]  gpio_ctrl,
  output logic signed [31:0] in_0,
  output logic signed [31:0] in_1,
  output logic               operands_valid,
  output logic               operand_update,
  output logic        [31:0] gpio_status
);

  localparam int unsigned DivW    = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SWEEP_DIV - 1);
  localparam logic        Step0Neg = (STEP_0 < 0);
  localparam logic        Step1Neg = (STEP_1 < 0);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPartial = 3'd1,
    StReady   = 3'd2,
    StSweep   = 3'd3,
    StDone    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic signed [31:0] in_0_q, in_0_d, in_1_q, in_1_d;
  logic               loaded_0_q, loaded_0_d, loaded_1_q, loaded_1_d;
  logic               overflow_q, overflow_d;
  logic        [7:0]  step_q, step_d;
  logic   [DivW-1:0]  div_q, div_d;
  logic               update_q, update_d;
  logic               valid_q, valid_d;
  logic        [31:0] status_q, status_d;
  logic        [3:0]  ctrl_prev_q;

  logic        [3:0]  ctrl_rise;
  logic               load_cmd, sweep_cmd, clear_cmd;
  logic signed [31:0] sum_0, sum_1;
  logic               ovf_0, ovf_1;

  // Commands fire on the rising edge of each control bit.
  assign ctrl_rise = gpio_ctrl & ~ctrl_prev_q;
  assign load_cmd  = ctrl_rise[0];
  assign sweep_cmd = ctrl_rise[2];
  assign clear_cmd = ctrl_rise[3];

  assign sum_0 = in_0_q + STEP_0;
  assign sum_1 = in_1_q + STEP_1;
  // Signed overflow: same-sign inputs producing the opposite sign.
  assign ovf_0 = (in_0_q[31] == Step0Neg) && (sum_0[31] != in_0_q[31]);
  assign ovf_1 = (in_1_q[31] == Step1Neg) && (sum_1[31] != in_1_q[31]);

  always_comb begin
    state_d    = state_q;
    in_0_d     = in_0_q;
    in_1_d     = in_1_q;
    loaded_0_d = loaded_0_q;
    loaded_1_d = loaded_1_q;
    overflow_d = overflow_q;
    step_d     = step_q;
    div_d      = div_q;
    update_d   = 1'b0;

    if (clear_cmd) begin
      state_d    = StIdle;
      in_0_d     = '0;
      in_1_d     = '0;
      loaded_0_d = 1'b0;
      loaded_1_d = 1'b0;
      overflow_d = 1'b0;
      step_d     = '0;
      div_d      = '0;
    end else if (load_cmd) begin
      update_d = 1'b1;
      if (gpio_ctrl[1]) begin
        in_1_d     = gpio_data;
        loaded_1_d = 1'b1;
      end else begin
        in_0_d     = gpio_data;
        loaded_0_d = 1'b1;
      end
      // From READY/SWEEP/DONE both operands are already loaded; a load there
      // (including a sweep abort) lands in READY.
      if (state_q == StIdle || state_q == StPartial) begin
        state_d = (loaded_0_d && loaded_1_d) ? StReady : StPartial;
      end else begin
        state_d = StReady;
      end
    end else begin
      unique case (state_q)
        StReady, StDone: begin
          if (sweep_cmd) begin
            state_d = StSweep;
            step_d  = '0;
            div_d   = '0;
          end
        end
        StSweep: begin
          if (div_q == DivLast) begin
            div_d = '0;
            if (in_0_q < SWEEP_LIMIT) begin
              in_0_d     = sum_0;
              in_1_d     = sum_1;
              overflow_d = overflow_q | ovf_0 | ovf_1;
              update_d   = 1'b1;
              if (step_q != 8'hFF) begin
                step_d = step_q + 8'd1;
              end
            end else begin
              state_d = StDone;
            end
          end else begin
            div_d = div_q + DivW'(1);
          end
        end
        default: ;
      endcase
    end

    valid_d  = (state_d == StReady) || (state_d == StSweep) || (state_d == StDone);
    status_d = {16'd0, step_d, 2'b00, loaded_1_d, loaded_0_d, overflow_d, state_d};
  end

  always_ff @(posedge sys_clk) begin
    // Tracked through reset so a bit held high across release is not an edge.
    ctrl_prev_q <= gpio_ctrl;
    if (sys_rst) begin
      state_q    <= StIdle;
      in_0_q     <= '0;
      in_1_q     <= '0;
      loaded_0_q <= 1'b0;
      loaded_1_q <= 1'b0;
      overflow_q <= 1'b0;
      step_q     <= '0;
      div_q      <= '0;
      update_q   <= 1'b0;
      valid_q    <= 1'b0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_0_q     <= in_0_d;
      in_1_q     <= in_1_d;
      loaded_0_q <= loaded_0_d;
      loaded_1_q <= loaded_1_d;
      overflow_q <= overflow_d;
      step_q     <= step_d;
      div_q      <= div_d;
      update_q   <= update_d;
      valid_q    <= valid_d;
      status_q   <= status_d;
    end
  end

  assign in_0           = in_0_q;
  assign in_1           = in_1_q;
  assign operands_valid = valid_q;
  assign operand_update = update_q;
  assign gpio_status    = status_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
module tb_adder_operand_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] data1, data2;
  logic [3:0]  ctrl1, ctrl2;
  logic [31:0] in0_1, in1_1, st1, in0_2, in1_2, st2;
  logic        val1, upd1, val2, upd2;

  int n_cmp;
  int n_err;

  logic [63:0] q1[$];
  logic [63:0] q2[$];
  logic [63:0] e1, e2;

  int k;
  int upd_edges[$];
  int done_edge;

  adder_operand_sequencer dut1 (
    .sys_clk        (clk),
    .sys_rst        (rst),
    .gpio_data      (data1),
    .gpio_ctrl      (ctrl1),
    .in_0           (in0_1),
    .in_1           (in1_1),
    .operands_valid (val1),
    .operand_update (upd1),
    .gpio_status    (st1)
  );

  adder_operand_sequencer #(
    .SWEEP_DIV (4)
  ) dut2 (
    .sys_clk        (clk),
    .sys_rst        (rst),
    .gpio_data      (data2),
    .gpio_ctrl      (ctrl2),
    .in_0           (in0_2),
    .in_1           (in1_2),
    .operands_valid (val2),
    .operand_update (upd2),
    .gpio_status    (st2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push1(input int a, input int b);
    q1.push_back({a, b});
  endtask

  task automatic push2(input int a, input int b);
    q2.push_back({a, b});
  endtask

  // Raise the given control bits for one sampled edge, then idle one cycle so
  // the next command sees a fresh rising edge. Returns just after a negedge.
  task automatic cmd(input int which, input logic [3:0] bits, input int data);
    if (which == 1) begin
      ctrl1 = bits;
      data1 = data;
    end else begin
      ctrl2 = bits;
      data2 = data;
    end
    @(negedge clk);
    if (which == 1) ctrl1 = 4'd0;
    else ctrl2 = 4'd0;
    @(negedge clk);
  endtask

  // Scoreboard monitors: every operand_update pulse must match the next
  // expected operand pair.
  always @(negedge clk) begin
    if (!rst && upd1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut1_unexpected_update: in_0=%h in_1=%h, expected no update", in0_1, in1_1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_upd_in_0", in0_1, e1[63:32]);
        chk("dut1_upd_in_1", in1_1, e1[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && upd2) begin
      if (q2.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut2_unexpected_update: in_0=%h in_1=%h, expected no update", in0_2, in1_2);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_upd_in_0", in0_2, e2[63:32]);
        chk("dut2_upd_in_1", in1_2, e2[31:0]);
      end
    end
  end

  initial begin
    clk   = 1'b0;
    rst   = 1'b1;
    ctrl1 = 4'd0;
    ctrl2 = 4'd0;
    data1 = 32'd0;
    data2 = 32'd0;
    n_cmp = 0;
    n_err = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_0", in0_1, 32'd0);
    chk("rst_in_1", in1_1, 32'd0);
    chk("rst_valid", 32'(val1), 32'd0);
    chk("rst_update", 32'(upd1), 32'd0);
    chk("rst_status", st1, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Load / valid
    push1(-10, 0);
    cmd(1, 4'b0001, -10);
    chk("load0_in_0", in0_1, 32'hFFFF_FFF6);
    chk("load0_state", 32'(st1[2:0]), 32'd1);
    chk("load0_valid", 32'(val1), 32'd0);
    push1(-10, -10);
    cmd(1, 4'b0011, -10);
    chk("load1_in_1", in1_1, 32'hFFFF_FFF6);
    chk("load1_state", 32'(st1[2:0]), 32'd2);
    chk("load1_valid", 32'(val1), 32'd1);
    chk("load1_loaded", 32'(st1[5:4]), 32'd3);

    // Default sweep from (-10,-10): 20 steps, DONE on the 21st tick
    for (int i = 1; i <= 20; i++) push1(-10 + i, -10 + 2 * i);
    cmd(1, 4'b0100, 0);
    k = 0;
    while (st1[2:0] != 3'd4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("sweep_done_cycle", 32'(k + 1), 32'd21);
    chk("sweep_in_0", in0_1, 32'd10);
    chk("sweep_in_1", in1_1, 32'd30);
    chk("sweep_steps", 32'(st1[15:8]), 32'd20);
    chk("sweep_ovf", 32'(st1[3]), 32'd0);
    chk("sweep_state", 32'(st1[2:0]), 32'd4);

    // SWEEP from DONE at the limit: next tick returns to DONE, no change
    cmd(1, 4'b0100, 0);
    chk("resweep_state", 32'(st1[2:0]), 32'd4);
    chk("resweep_in_0", in0_1, 32'd10);

    // Priority: LOAD+CLEAR mid-sweep clears everything
    push1(-10, 30);
    cmd(1, 4'b0001, -10);
    push1(-10, -10);
    cmd(1, 4'b0011, -10);
    push1(-9, -8);
    cmd(1, 4'b0100, 0);
    cmd(1, 4'b1001, 55);
    chk("clr_in_0", in0_1, 32'd0);
    chk("clr_in_1", in1_1, 32'd0);
    chk("clr_status", st1, 32'd0);
    chk("clr_valid", 32'(val1), 32'd0);

    // LOAD alone mid-sweep aborts to READY
    push1(-10, 0);
    cmd(1, 4'b0001, -10);
    push1(-10, -10);
    cmd(1, 4'b0011, -10);
    push1(-9, -8);
    cmd(1, 4'b0100, 0);
    push1(5, -8);
    cmd(1, 4'b0001, 5);
    repeat (5) @(negedge clk);
    chk("abort_state", 32'(st1[2:0]), 32'd2);
    chk("abort_in_0", in0_1, 32'd5);
    chk("abort_in_1", in1_1, 32'hFFFF_FFF8);
    chk("abort_steps", 32'(st1[15:8]), 32'd1);

    // Overflow wrap and sticky flag
    cmd(1, 4'b1000, 0);
    push1(-100, 0);
    cmd(1, 4'b0001, -100);
    push1(-100, 32'h7FFF_FFFF);
    cmd(1, 4'b0011, 32'h7FFF_FFFF);
    push1(-99, 32'h8000_0001);
    cmd(1, 4'b0100, 0);
    chk("ovf_in_1", in1_1, 32'h8000_0001);
    chk("ovf_flag", 32'(st1[3]), 32'd1);
    push1(3, 32'h8000_0001);
    cmd(1, 4'b0001, 3);
    chk("ovf_sticky", 32'(st1[3]), 32'd1);
    chk("ovf_load_state", 32'(st1[2:0]), 32'd2);
    cmd(1, 4'b1000, 0);
    chk("ovf_cleared", st1, 32'd0);

    // Divider: SWEEP_DIV=4 from (8,0)
    push2(8, 0);
    cmd(2, 4'b0001, 8);
    push2(8, 0);
    cmd(2, 4'b0011, 0);
    push2(9, 2);
    push2(10, 4);
    cmd(2, 4'b0100, 0);
    done_edge = 0;
    for (int j = 1; j <= 50 && done_edge == 0; j++) begin
      @(negedge clk);
      if (upd2) upd_edges.push_back(j + 1);
      if (st2[2:0] == 3'd4) done_edge = j + 1;
    end
    chk("div_n_steps", 32'(upd_edges.size()), 32'd2);
    if (upd_edges.size() == 2) begin
      chk("div_step1_cycle", 32'(upd_edges[0]), 32'd4);
      chk("div_step2_cycle", 32'(upd_edges[1]), 32'd8);
    end
    chk("div_done_cycle", 32'(done_edge), 32'd12);
    chk("div_in_0", in0_2, 32'd10);
    chk("div_in_1", in1_2, 32'd4);

    // LOAD held high through reset release must not fire
    rst   = 1'b1;
    ctrl1 = 4'b0001;
    data1 = 32'd77;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstedge_in_0", in0_1, 32'd0);
    chk("rstedge_state", 32'(st1[2:0]), 32'd0);
    ctrl1 = 4'd0;
    @(negedge clk);
    push1(77, 0);
    cmd(1, 4'b0001, 77);
    repeat (2) @(negedge clk);
    chk("rstedge_load_in_0", in0_1, 32'd77);
    chk("rstedge_load_state", 32'(st1[2:0]), 32'd1);

    // Every expected update must have been observed
    chk("dut1_pending", 32'(q1.size()), 32'd0);
    chk("dut2_pending", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
